// File: rtl/hdlc_rx_frame_fifo_pkg.sv
// hdlc_rx_frame_fifo_pkg: shared defaults and write-FSM state type for the HDLC Rx frame buffer
package hdlc_rx_frame_fifo_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 128;
  localparam int MAX_FRAMES_DEF = 4;
  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;
endpackage

// File: rtl/hdlc_rx_frame_fifo_if.sv
// hdlc_rx_frame_fifo_if: Rx-channel write side and bus read side of the frame buffer
interface hdlc_rx_frame_fifo_if #(
  parameter int DATA_W = hdlc_rx_frame_fifo_pkg::DATA_W_DEF,
  parameter int DEPTH = hdlc_rx_frame_fifo_pkg::DEPTH_DEF,
  parameter int MAX_FRAMES = hdlc_rx_frame_fifo_pkg::MAX_FRAMES_DEF
);
  localparam int FSIZE_W = $clog2(DEPTH + 1);
  localparam int FCNT_W = $clog2(MAX_FRAMES + 1);
  logic Wr_Start, Wr_Valid, Wr_EoF, Wr_Drop, Rd_En, Rd_Flush;
  logic [DATA_W-1:0] Wr_Data, Rd_Data;
  logic Rd_Ready, Rd_FrameDone, Overflow;
  logic [FSIZE_W-1:0] Rd_FrameSize;
  logic [FCNT_W-1:0] Frames;
  modport master (
    output Wr_Start, Wr_Valid, Wr_Data, Wr_EoF, Wr_Drop, Rd_En, Rd_Flush,
    input Rd_Data, Rd_Ready, Rd_FrameSize, Rd_FrameDone, Overflow, Frames
  );
  modport slave (
    input Wr_Start, Wr_Valid, Wr_Data, Wr_EoF, Wr_Drop, Rd_En, Rd_Flush,
    output Rd_Data, Rd_Ready, Rd_FrameSize, Rd_FrameDone, Overflow, Frames
  );
endinterface

// File: rtl/hdlc_desc_fifo.sv
// hdlc_desc_fifo: queue of committed frame sizes; head is the frame currently being read
module hdlc_desc_fifo #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(N+1)-1:0] count_o
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  logic [W-1:0] mem_q [N];
  logic [IW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q == LAST ? '0 : wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q == LAST ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  assign head_o = mem_q[rd_q];
  assign full_o = cnt_q == CW'(N);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/hdlc_rx_frame_fifo.sv
// hdlc_rx_frame_fifo: circular byte store holding whole HDLC frames; dropped/overflowed frames are rewound
module hdlc_rx_frame_fifo
  import hdlc_rx_frame_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int MAX_FRAMES = MAX_FRAMES_DEF
) (
  input logic Clk,
  input logic Rst,
  hdlc_rx_frame_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FSIZE_W = $clog2(DEPTH + 1);
  wr_state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  logic [FSIZE_W-1:0] cur_size_q, cur_size_d, cons_q, cons_d, head, remaining, size_fin;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic ovf_q, ovf_d, done_q, push, pop, take, full, d_full, d_empty, ready, in_recv;
  assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign take = in_recv && bus.Wr_Valid && !full;
  assign size_fin = cur_size_q + FSIZE_W'(take);
  assign ready = !d_empty;
  assign remaining = head - cons_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      wr_commit_q <= '0;
      rd_ptr_q <= '0;
      cur_size_q <= '0;
      cons_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q <= rd_ptr_d;
      cur_size_q <= cur_size_d;
      cons_q <= cons_d;
      ovf_q <= ovf_d;
      done_q <= pop;
    end
  end
  always_ff @(posedge Clk) begin
    if (take) mem_q[wr_ptr_q[AW-1:0]] <= bus.Wr_Data;
  end
  always_comb begin
    state_d = state_q;
    if (bus.Wr_Drop) state_d = IDLE;
    else if (bus.Wr_Start) state_d = RECV;
    else if (state_q == RECV) state_d = bus.Wr_EoF ? IDLE : (bus.Wr_Valid && full) ? DISCARD : RECV;
    else if (state_q == DISCARD && bus.Wr_EoF) state_d = IDLE;
  end
  // Start/Drop/overflow all rewind to the last committed frame boundary.
  always_comb begin
    in_recv = state_q == RECV && !bus.Wr_Drop && !bus.Wr_Start;
    ovf_d = in_recv && ((bus.Wr_Valid && full) || (bus.Wr_EoF && size_fin != '0 && d_full));
    push = in_recv && bus.Wr_EoF && !ovf_d && size_fin != '0;
    wr_commit_d = push ? wr_ptr_q + PW'(take) : wr_commit_q;
    wr_ptr_d = (bus.Wr_Drop || bus.Wr_Start || ovf_d) ? wr_commit_q : wr_ptr_q + PW'(take);
    cur_size_d = bus.Wr_Start ? '0 : size_fin;
    pop = ready && (bus.Rd_Flush || (bus.Rd_En && remaining == FSIZE_W'(1)));
    rd_ptr_d = !ready ? rd_ptr_q : bus.Rd_Flush ? rd_ptr_q + PW'(remaining) : rd_ptr_q + PW'(bus.Rd_En);
    cons_d = pop ? '0 : cons_q + FSIZE_W'(ready && bus.Rd_En);
  end
  hdlc_desc_fifo #(.W(FSIZE_W), .N(MAX_FRAMES)) u_desc (
    .clk(Clk),
    .rst_n(Rst),
    .push_i(push),
    .pop_i(pop),
    .din_i(size_fin),
    .head_o(head),
    .full_o(d_full),
    .empty_o(d_empty),
    .count_o(bus.Frames)
  );
  assign bus.Rd_Data = ready ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign bus.Rd_Ready = ready;
  assign bus.Rd_FrameSize = ready ? head : '0;
  assign bus.Rd_FrameDone = done_q;
  assign bus.Overflow = ovf_q;
endmodule
